// File: rtl/regfile_write_queue.sv
// regfile_write_queue: DEPTH-entry write buffer between write-back and the
// 32 x 64-bit register bank. Requests drain one per cycle, head first, as a
// one-hot register enable plus a shared data bus. Register X31 is hardwired
// zero, so writes to it are consumed without enabling any register.
// Optional feature macro: REGWQ_FORWARD_EN builds the pending-write probe
// (rd_hit/rd_data). Without it, both outputs are tied to zero.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    hold,
  output logic [(2**ADDR_W)-1:0]  reg_en,
  output logic [WIDTH-1:0]        reg_din,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_hit,
  output logic [WIDTH-1:0]        rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG  = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  EMPTY_CNT = {CNT_W{1'b0}};

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [WIDTH-1:0]  data_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] head_addr_s;

  // No fall-through: a full queue refuses even when the head retires this cycle.
  assign wr_ready    = (count_r < FULL_CNT);
  assign push_s      = wr_valid & wr_ready;
  assign pop_s       = (count_r != EMPTY_CNT) & ~hold;
  assign head_addr_s = addr_mem_r[head_r];
  assign count       = count_r;

  // Entry storage: capture the accepted request at the tail slot.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      addr_mem_r[tail_r] <= wr_addr;
      data_mem_r[tail_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain port: present the head entry to the bank, suppressing X31 writes.
  always_comb begin
    reg_en  = {NREG{1'b0}};
    reg_din = {WIDTH{1'b0}};
    if (count_r != EMPTY_CNT) begin
      reg_din = data_mem_r[head_r];
    end else begin
      reg_din = {WIDTH{1'b0}};
    end
    if (pop_s && (head_addr_s != ZERO_REG)) begin
      reg_en[head_addr_s] = 1'b1;
    end else begin
      reg_en = {NREG{1'b0}};
    end
  end

`ifdef REGWQ_FORWARD_EN
  // Pending-write probe: scan oldest to youngest so the youngest match wins;
  // the entry retiring this cycle is still considered pending.
  always_comb begin
    logic [PTR_W-1:0] idx_s;
    rd_hit  = 1'b0;
    rd_data = {WIDTH{1'b0}};
    idx_s   = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) && (addr_mem_r[idx_s] == rd_addr) &&
          (rd_addr != ZERO_REG)) begin
        rd_hit  = 1'b1;
        rd_data = data_mem_r[idx_s];
      end else begin
        rd_hit  = rd_hit;
        rd_data = rd_data;
      end
    end
  end
`else
  logic unused_rd_addr_s;
  assign unused_rd_addr_s = ^rd_addr;
  assign rd_hit  = 1'b0;
  assign rd_data = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: each issued write that should
// reach the bank is queued as an expectation; a negedge monitor pops and
// compares on every asserted enable. Directed checks cover occupancy,
// backpressure, X31 suppression, forwarding and reset.
module tb_regfile_write_queue;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        hold;
  logic [31:0] reg_en;
  logic [63:0] reg_din;
  logic [2:0]  count;
  logic [4:0]  rd_addr;
  logic        rd_hit;
  logic [63:0] rd_data;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

`ifdef REGWQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  regfile_write_queue dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hold     (hold),
    .reg_en   (reg_en),
    .reg_din  (reg_din),
    .count    (count),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] a, input logic [63:0] d);
    exp_t e;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (a != 5'd31) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every asserted enable must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (reg_en != 32'h0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got reg_en=%0h reg_din=%0h expected no drain", reg_en, reg_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ((reg_en !== (32'h1 << mon_e.addr)) || (reg_din !== mon_e.data)) begin
          errors++;
          $display("FAIL drain_order: got reg_en=%0h reg_din=%0h expected reg_en=%0h reg_din=%0h",
                   reg_en, reg_din, 32'h1 << mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 64'd0;
    hold = 1'b0; rd_addr = 5'd0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_en", 64'(reg_en), 64'd0);
    chk("rst_din", reg_din, 64'd0);
    chk("rst_hit", 64'(rd_hit), 64'd0);
    chk("rst_rdata", rd_data, 64'd0);

    // Single write, no hold: visible the cycle after acceptance
    step();
    send(5'd3, 64'd27);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_en", 64'(reg_en), 64'h8);
    chk("t1_din", reg_din, 64'd27);
    step();
    @(negedge clk);
    chk("t1_count_after", 64'(count), 64'd0);
    chk("t1_en_after", 64'(reg_en), 64'd0);

    // Fill under hold, 5th request refused, then drain in order
    step();
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(5'(i), 64'(10 * i));
      step();
    end
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 64'd50;
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(wr_ready), 64'd0);
    chk("full_en", 64'(reg_en), 64'd0);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("full_count_kept", 64'(count), 64'd4);
    step();
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("drain_en", 64'(reg_en), 64'(32'h1 << i));
      chk("drain_din", reg_din, 64'(10 * i));
      step();
    end
    @(negedge clk);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_en_idle", 64'(reg_en), 64'd0);

    // Write to X31: accepted and popped, no enable
    step();
    send(5'd31, 64'hFFFF);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("x31_count", 64'(count), 64'd1);
    chk("x31_en", 64'(reg_en), 64'd0);
    chk("x31_din", reg_din, 64'hFFFF);
    step();
    @(negedge clk);
    chk("x31_count_after", 64'(count), 64'd0);
    chk("x31_en_after", 64'(reg_en), 64'd0);

    // Forwarding probe: youngest pending write wins, X31 never hits
    step();
    hold = 1'b1;
    send(5'd7, 64'd5);
    step();
    send(5'd7, 64'd9);
    step();
    wr_valid = 1'b0;
    rd_addr = 5'd7;
    @(negedge clk);
    chk("fwd_hit", 64'(rd_hit), FWD ? 64'd1 : 64'd0);
    chk("fwd_data", rd_data, FWD ? 64'd9 : 64'd0);
    step();
    rd_addr = 5'd31;
    @(negedge clk);
    chk("fwd_x31_hit", 64'(rd_hit), 64'd0);
    chk("fwd_x31_data", rd_data, 64'd0);
    step();
    rd_addr = 5'd7;
    hold = 1'b0;
    @(negedge clk);
    chk("fwd_popping_hit", 64'(rd_hit), FWD ? 64'd1 : 64'd0);
    chk("fwd_popping_data", rd_data, FWD ? 64'd9 : 64'd0);
    step();
    @(negedge clk);
    chk("fwd_last_hit", 64'(rd_hit), FWD ? 64'd1 : 64'd0);
    chk("fwd_last_count", 64'(count), 64'd1);
    step();
    @(negedge clk);
    chk("fwd_empty_hit", 64'(rd_hit), 64'd0);
    chk("fwd_empty_count", 64'(count), 64'd0);

    // Simultaneous push and pop at count 3; pointers wrap, order preserved
    step();
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      send(5'(10 + j), 64'(100 + j));
      step();
    end
    hold = 1'b0;
    for (int j = 0; j < 6; j++) begin
      send(5'(13 + j), 64'(103 + j));
      @(negedge clk);
      chk("pushpop_count", 64'(count), 64'd3);
      step();
    end
    wr_valid = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("pushpop_drained", 64'(count), 64'd0);

    // Reset with three entries queued: nothing reaches the bank
    step();
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      send(5'(20 + j), 64'(200 + j));
      step();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("prereset_count", 64'(count), 64'd3);
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    hold = 1'b0;
    rd_addr = 5'd20;
    @(negedge clk);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ready", 64'(wr_ready), 64'd1);
    chk("mid_rst_en", 64'(reg_en), 64'd0);
    chk("mid_rst_din", reg_din, 64'd0);
    chk("mid_rst_hit", 64'(rd_hit), 64'd0);
    repeat (4) step();
    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
